// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Optional performance counters are compiled in with `define MIPS_FETCH_PERF_EN.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [23:0] ROM_BASE = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
`ifdef MIPS_FETCH_PERF_EN
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count,
`endif
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        err_d;
    logic        fetch_inc;
    logic        stall_inc;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        pc_fault;
    logic        target_fault;

    assign imem_addr       = pc_q;
    assign pc4             = pc_q + 32'd4;
    assign jump_target     = {pc4[31:28], jump_index, 2'b00};
    assign redirect        = branch_taken | jump;
    // Branch comes from an older instruction than the jump, so it takes priority.
    assign redirect_target = branch_taken ? branch_target : jump_target;
    assign pc_fault        = (pc_q[1:0] != 2'b00) || (pc_q[31:8] != ROM_BASE);
    assign target_fault    = redirect && (redirect_target[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = if_id_instr;
        pc4_d     = if_id_pc4;
        valid_d   = if_id_valid;
        err_d     = fetch_err;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d    = RESET_PC;
                valid_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                stall_inc = stall && !redirect;
                if (pc_fault || target_fault) begin
                    // Freeze the PC at the faulting fetch so it can be inspected after halt.
                    state_d = HALTED;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    instr_d = 32'd0;
                end else begin
                    if (redirect)
                        pc_d = redirect_target;
                    else if (!stall)
                        pc_d = pc4;

                    if (redirect || flush) begin
                        valid_d = 1'b0;
                        instr_d = 32'd0;
                    end else if (!stall) begin
                        instr_d   = imem_data;
                        pc4_d     = pc4;
                        valid_d   = 1'b1;
                        fetch_inc = 1'b1;
                    end
                end
            end
            HALTED: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_id_instr <= instr_d;
            if_id_pc4   <= pc4_d;
            if_id_valid <= valid_d;
            fetch_err   <= err_d;
        end
    end

`ifdef MIPS_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_count <= 32'd0;
            perf_stall_count <= 32'd0;
        end else begin
            if (fetch_inc)
                perf_fetch_count <= perf_fetch_count + 32'd1;
            if (stall_inc)
                perf_stall_count <= perf_stall_count + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_inc ^ stall_inc;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: behavioural reference model compared every cycle plus directed literal checks.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_err;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_stall_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [32];

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr[6:2]];

    mips_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .ROM_BASE(24'h000000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .stall(stall),
        .flush(flush),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_index(jump_index),
        .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid),
`ifdef MIPS_FETCH_PERF_EN
        .perf_fetch_count(perf_fetch_count),
        .perf_stall_count(perf_stall_count),
`endif
        .fetch_err(fetch_err)
    );

    // Reference model: mode 0 = waiting after reset, 1 = fetching, 2 = halted.
    int          m_mode;
    bit          m_live = 1'b0;
    logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
    logic        m_valid, m_err;

    always @(posedge clk) begin
        logic [31:0] nxt, tgt;
        logic        redir, bad;
        if (reset) begin
            m_live = 1'b1;
            m_mode = 0;
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_err = 1'b0; m_fcnt = 0; m_scnt = 0;
        end else if (m_live) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                nxt   = m_pc + 32'd4;
                redir = branch_taken || jump;
                tgt   = branch_taken ? branch_target
                                     : ((nxt & 32'hF000_0000) | (32'(jump_index) << 2));
                bad   = ((m_pc & 32'd3) != 0) || ((m_pc >> 8) != 0) ||
                        (redir && ((tgt & 32'd3) != 0));
                if (stall && !redir) m_scnt = m_scnt + 1;
                if (bad) begin
                    m_mode = 2; m_err = 1'b1; m_valid = 1'b0; m_instr = 32'h0;
                end else begin
                    if (redir || flush) begin
                        m_valid = 1'b0; m_instr = 32'h0;
                    end else if (!stall) begin
                        m_instr = rom[m_pc[6:2]]; m_pc4 = nxt; m_valid = 1'b1;
                        m_fcnt = m_fcnt + 1;
                    end
                    if (redir) m_pc = tgt;
                    else if (!stall) m_pc = nxt;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("model_imem_addr", imem_addr, m_pc);
            check("model_instr", if_id_instr, m_instr);
            check("model_pc4", if_id_pc4, m_pc4);
            check("model_valid", 32'(if_id_valid), 32'(m_valid));
            check("model_err", 32'(fetch_err), 32'(m_err));
`ifdef MIPS_FETCH_PERF_EN
            check("model_perf_fetch", perf_fetch_count, m_fcnt);
            check("model_perf_stall", perf_stall_count, m_scnt);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_index = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 + 32'(i);
        rom[0] = 32'h8C02_0004;
        rom[7] = 32'h0042_1020;
        clear_inputs();
        reset = 1;
        tick(); tick();
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);

        // Free-running fetch after reset release
        reset = 0;
        tick();
        check("idle_addr", imem_addr, 32'h0);
        check("idle_valid", 32'(if_id_valid), 32'h0);
        tick();
        check("first_instr", if_id_instr, 32'h8C02_0004);
        check("first_pc4", if_id_pc4, 32'h4);
        check("first_valid", 32'(if_id_valid), 32'h1);
        check("first_addr", imem_addr, 32'h4);
        tick();
        check("second_addr", imem_addr, 32'h8);
        check("second_instr", if_id_instr, 32'h2000_0001);

        // Three-cycle stall at PC 0x08
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_addr", imem_addr, 32'h8);
            check("stall_instr", if_id_instr, 32'h2000_0001);
            check("stall_pc4", if_id_pc4, 32'h8);
        end
        stall = 0;
        tick();
        check("resume_addr", imem_addr, 32'hC);
        check("resume_instr", if_id_instr, 32'h2000_0002);

        // Jump index 7 from PC 0x0C
        jump = 1; jump_index = 26'd7;
        tick();
        check("jump_addr", imem_addr, 32'h1C);
        check("jump_valid", 32'(if_id_valid), 32'h0);
        clear_inputs();
        tick();
        check("jump_instr", if_id_instr, 32'h0042_1020);
        check("jump_pc4", if_id_pc4, 32'h20);
        check("jump_valid2", 32'(if_id_valid), 32'h1);

        // Branch and jump together under stall: branch wins
        stall = 1; branch_taken = 1; branch_target = 32'h10; jump = 1; jump_index = 26'd7;
        tick();
        check("bj_addr", imem_addr, 32'h10);
        check("bj_valid", 32'(if_id_valid), 32'h0);
        clear_inputs();
        tick();
        check("bj_instr", if_id_instr, 32'h2000_0004);
        check("bj_pc4", if_id_pc4, 32'h14);

        // Flush squashes but PC advances
        flush = 1;
        tick();
        check("flush_valid", 32'(if_id_valid), 32'h0);
        check("flush_addr", imem_addr, 32'h18);
        flush = 0;
        tick();

        // Reset during stall
        stall = 1; reset = 1;
        tick();
        check("rst_stall_addr", imem_addr, 32'h0);
        check("rst_stall_valid", 32'(if_id_valid), 32'h0);
        check("rst_stall_instr", if_id_instr, 32'h0);
        reset = 0; stall = 0;
        tick(); tick();
        check("pre_bad_addr", imem_addr, 32'h4);

        // Misaligned branch target halts
        branch_taken = 1; branch_target = 32'h12;
        tick();
        check("bad_err", 32'(fetch_err), 32'h1);
        check("bad_valid", 32'(if_id_valid), 32'h0);
        check("bad_addr", imem_addr, 32'h4);
        clear_inputs();
        tick(); tick();
        check("halt_addr", imem_addr, 32'h4);
        check("halt_err", 32'(fetch_err), 32'h1);
        reset = 1;
        tick();
        check("halt_rst_addr", imem_addr, 32'h0);
        check("halt_rst_err", 32'(fetch_err), 32'h0);

        // Run off the end of the ROM window
        reset = 0;
        for (int k = 0; k < 65; k++) tick();
        check("end_addr", imem_addr, 32'h100);
        check("end_pc4", if_id_pc4, 32'h100);
        check("end_valid", 32'(if_id_valid), 32'h1);
        check("end_err", 32'(fetch_err), 32'h0);
        tick();
        check("oob_err", 32'(fetch_err), 32'h1);
        check("oob_valid", 32'(if_id_valid), 32'h0);
        check("oob_addr", imem_addr, 32'h100);
`ifdef MIPS_FETCH_PERF_EN
        check("perf_fetch_halt", perf_fetch_count, 32'd64);
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
